mux4_sched: RTL

Round-robin scheduler that shares the 4:1 gate-level select mux (inputs in0..in3, selects sel1/sel0, single output) among four requesters. It drives the mux select lines and waits a programmable settle window after every select change, covering the mux's worst-case not/and/and/or/or propagation path. It then qualifies the mux output with `out_valid` and holds the grant until the requester releases it or a hold limit forces rotation. It sits beside the mux as its only select driver.

---
 rtl/mux4_sched_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 20 ++
 rtl/mux4_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux4_sched_pkg.sv
// Shared types and select encoding for the round-robin scheduler that owns
// the select lines of the 4:1 gate-level mux.
package mux4_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } state_t;

  typedef logic [1:0] idx_t;

  // {sel1, sel0} is simply the binary index of the routed mux input.
  function automatic logic [1:0] sel_encode(input idx_t i);
    return i;
  endfunction

  function automatic logic [3:0] idx_onehot(input idx_t i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after ptr, mod 4.
module rr_pick4
  import mux4_sched_pkg::*;
(
  input  logic [3:0] req,
  input  idx_t       ptr,
  output idx_t       idx,
  output logic       any
);

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + idx_t'(k)]) idx = ptr + idx_t'(k);
    end
    any = |req;
  end

endmodule

// File: rtl/mux4_sched.sv
// Round-robin owner of the 4:1 mux selects: settles the mux after every
// select change, then qualifies its output with out_valid until release.
module mux4_sched
  import mux4_sched_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int MAX_HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       sel1,
  output logic       sel0,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic       busy
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [SW-1:0] SCNT_INIT = SW'(SETTLE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  // Handshake: req[i] is held high while requester i wants in{i} routed;
  // gnt[i] acknowledges ownership, and the mux output is usable only while
  // out_valid is high. Dropping req[i] releases the grant on the next edge.

  state_t          state;
  idx_t            ptr;
  idx_t            cur;
  idx_t            pick;
  logic            pick_any;
  logic [SW-1:0]   scnt;
  logic [HW-1:0]   hcnt;
  logic            settled;
  logic            others;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick),
    .any (pick_any)
  );

  assign others       = |(req & ~idx_onehot(cur));
  assign {sel1, sel0} = sel_encode(cur);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      scnt      <= '0;
      hcnt      <= '0;
      settled   <= 1'b0;
      gnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            cur  <= pick;
            gnt  <= idx_onehot(pick);
            hcnt <= '0;
            // Reusing an already-settled select needs no new settle window.
            if (pick == cur && settled) begin
              state     <= GRANT;
              out_valid <= 1'b1;
            end else begin
              settled <= 1'b0;
              scnt    <= SCNT_INIT;
              state   <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (!req[cur]) begin
            state <= IDLE;
            ptr   <= cur + 2'd1;
            gnt   <= '0;
          end else if (scnt == '0) begin
            state     <= GRANT;
            settled   <= 1'b1;
            hcnt      <= '0;
            out_valid <= 1'b1;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        GRANT: begin
          if (!req[cur] || (hcnt == HOLD_LAST && others)) begin
            state     <= IDLE;
            ptr       <= cur + 2'd1;
            gnt       <= '0;
            out_valid <= 1'b0;
          end else if (hcnt == HOLD_LAST) begin
            hcnt <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
